a2o_wb: RTL and testbench

- Memory-side bridge for the A2O core node.
- Accepts one 16-byte core load/store request at a time and routes it by address:
  - below IO_BASE: to the 128-bit direct-attach memory port;
  - at or above IO_BASE: to a 32-bit Wishbone classic master (single-word I/O access).
- Returns exactly one response per request. Sits between the core's L2-side request path and the node memory/peripheral fabric.

---
 rtl/a2o_wb.sv | 182 ++++++++++++++++++
 tb/tb_a2o_wb.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/a2o_wb.sv
`default_nettype none
// ============================================================================
// Module      : a2o_wb
// Description : Memory-side bridge for the A2O core node. Takes one 16-byte
//               load/store at a time and routes it either to the 128-bit
//               direct-attach memory port or, at/above IO_BASE, to a 32-bit
//               Wishbone classic master as a single-word I/O access.
// Revision    : 1.0 - initial release
// ============================================================================
module a2o_wb #(
  parameter logic [31:0] IO_BASE    = 32'h8000_0000,
  parameter int unsigned WB_TIMEOUT = 255
) (
  input  logic         clk_1x,
  input  logic         rst_b,
  // core request / response
  input  logic         req_val,
  output logic         req_rdy,
  input  logic         req_wr,
  input  logic [0:31]  req_adr,
  input  logic [0:15]  req_be,
  input  logic [0:127] req_dat,
  output logic         rsp_val,
  output logic [0:127] rsp_dat,
  output logic         rsp_err,
  // direct-attach memory
  output logic [0:31]  mem_adr,
  input  logic [0:127] mem_dat,
  output logic         mem_wr_val,
  output logic [0:15]  mem_wr_be,
  output logic [0:127] mem_wr_dat,
  // Wishbone classic master
  output logic         wb_stb,
  output logic         wb_cyc,
  output logic [31:0]  wb_adr,
  output logic         wb_we,
  output logic [3:0]   wb_sel,
  output logic [31:0]  wb_datw,
  input  logic         wb_ack,
  input  logic [31:0]  wb_datr
);

  localparam int CNT_W = $clog2(WB_TIMEOUT + 1);
  // Last cycle in which an ack is still honoured; an ack here beats timeout.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WB_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    WB   = 2'd2,
    RSP  = 2'd3
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic           wr_q;
  logic [1:0]     wsel_q;
  logic [0:15]    be_q;
  logic [0:127]   dat_q;
  logic [CNT_W-1:0] cnt;
  logic           accept;
  logic           to_io;
  logic [1:0]     wsel_req;
  logic           sel_zero;
  logic           timeout;
  logic [0:127]   rd_place;

  assign accept   = req_val & rst_b & (state == IDLE);
  assign to_io    = (req_adr >= IO_BASE);
  assign wsel_req = req_adr[28:29];
  // A zero byte-enable nibble for the addressed word means nothing to move.
  assign sel_zero = (req_be[4*wsel_req +: 4] == 4'b0000);
  assign timeout  = (cnt == CNT_LAST);

  assign mem_wr_be  = be_q;
  assign mem_wr_dat = dat_q;

  // State register.
  always_ff @(posedge clk_1x or negedge rst_b) begin
    if (!rst_b) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and per-state strobes; ready is held low while reset is asserted.
  always_comb begin
    state_nxt  = state;
    req_rdy    = 1'b0;
    rsp_val    = 1'b0;
    mem_wr_val = 1'b0;
    case (state)
      IDLE: begin
        req_rdy = rst_b;
        if (accept) begin
          if (!to_io)        state_nxt = MEM;
          else if (sel_zero) state_nxt = RSP;
          else               state_nxt = WB;
        end
      end
      MEM: begin
        mem_wr_val = wr_q;
        state_nxt  = RSP;
      end
      WB: begin
        if (wb_ack || timeout) state_nxt = RSP;
      end
      RSP: begin
        rsp_val   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Steer the 32-bit read word into its big-endian lane of the 128-bit response.
  always_comb begin
    rd_place = '0;
    rd_place[32*wsel_q +: 32] = wb_datr;
  end

  // Request capture, memory/Wishbone drive, timeout counter and response data.
  always_ff @(posedge clk_1x or negedge rst_b) begin
    if (!rst_b) begin
      wr_q    <= 1'b0;
      wsel_q  <= 2'b00;
      be_q    <= '0;
      dat_q   <= '0;
      cnt     <= '0;
      mem_adr <= '0;
      wb_cyc  <= 1'b0;
      wb_stb  <= 1'b0;
      wb_adr  <= '0;
      wb_we   <= 1'b0;
      wb_sel  <= '0;
      wb_datw <= '0;
      rsp_dat <= '0;
      rsp_err <= 1'b0;
    end else begin
      if (accept) begin
        wr_q   <= req_wr;
        wsel_q <= wsel_req;
        be_q   <= req_be;
        dat_q  <= req_dat;
        if (!to_io) begin
          mem_adr <= {req_adr[0:27], 4'b0000};
        end else begin
          wb_adr  <= {req_adr[0:29], 2'b00};
          wb_datw <= req_dat[32*wsel_req +: 32];
          wb_sel  <= req_be[4*wsel_req +: 4];
          wb_we   <= req_wr;
          wb_cyc  <= ~sel_zero;
          wb_stb  <= ~sel_zero;
          cnt     <= '0;
          if (sel_zero) begin
            rsp_dat <= '0;
            rsp_err <= 1'b0;
          end
        end
      end
      if (state == MEM) begin
        rsp_dat <= wr_q ? '0 : mem_dat;
        rsp_err <= 1'b0;
      end
      if (state == WB) begin
        if (wb_ack) begin
          wb_cyc  <= 1'b0;
          wb_stb  <= 1'b0;
          rsp_dat <= wr_q ? '0 : rd_place;
          rsp_err <= 1'b0;
        end else if (timeout) begin
          wb_cyc  <= 1'b0;
          wb_stb  <= 1'b0;
          rsp_dat <= '0;
          rsp_err <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_a2o_wb.sv
`default_nettype none
// ============================================================================
// Module      : tb_a2o_wb
// Description : Self-checking bench for a2o_wb. Directed requests with a
//               response model, a per-cycle compare process and literal pins.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_a2o_wb;

  localparam logic [31:0] IO_BASE    = 32'h8000_0000;
  localparam int          WB_TIMEOUT = 255;

  logic         clk;
  logic         rst_b;
  logic         req_val, req_rdy, req_wr;
  logic [31:0]  req_adr;
  logic [15:0]  req_be;
  logic [127:0] req_dat;
  logic         rsp_val, rsp_err;
  logic [127:0] rsp_dat;
  logic [31:0]  mem_adr;
  logic [127:0] mem_dat;
  logic         mem_wr_val;
  logic [15:0]  mem_wr_be;
  logic [127:0] mem_wr_dat;
  logic         wb_stb, wb_cyc, wb_we, wb_ack;
  logic [31:0]  wb_adr, wb_datw, wb_datr;
  logic [3:0]   wb_sel;

  typedef struct {
    logic [127:0] dat;
    logic         err;
  } rsp_t;

  rsp_t         exp_q[$];
  rsp_t         cmp_e;
  bit           busy;
  logic [127:0] last_dat;
  logic         last_err;
  int           n_pass;
  int           n_total;
  logic [127:0] gd;
  logic         ge;

  wire [378:0] outs_all = {req_rdy, rsp_val, rsp_dat, rsp_err, mem_adr, mem_wr_val,
                           mem_wr_be, mem_wr_dat, wb_stb, wb_cyc, wb_adr, wb_we,
                           wb_sel, wb_datw};

  a2o_wb #(.IO_BASE(IO_BASE), .WB_TIMEOUT(WB_TIMEOUT)) dut (
    .clk_1x(clk), .rst_b(rst_b),
    .req_val(req_val), .req_rdy(req_rdy), .req_wr(req_wr), .req_adr(req_adr),
    .req_be(req_be), .req_dat(req_dat),
    .rsp_val(rsp_val), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .mem_adr(mem_adr), .mem_dat(mem_dat), .mem_wr_val(mem_wr_val),
    .mem_wr_be(mem_wr_be), .mem_wr_dat(mem_wr_dat),
    .wb_stb(wb_stb), .wb_cyc(wb_cyc), .wb_adr(wb_adr), .wb_we(wb_we),
    .wb_sel(wb_sel), .wb_datw(wb_datw), .wb_ack(wb_ack), .wb_datr(wb_datr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: one fixed line for the load test, a pattern elsewhere.
  function automatic logic [127:0] memfn(input logic [31:0] a);
    if (a == 32'h0000_1230) return 128'h00112233_44556677_8899AABB_CCDDEEFF;
    return {a, ~a, a ^ 32'h5A5A_A5A5, a + 32'h1111_1111};
  endfunction

  assign mem_dat = memfn(mem_adr);

  // Expected response of one request, from the routing and lane rules.
  function automatic rsp_t model_rsp(input logic wr, input logic [31:0] adr,
                                     input logic [15:0] be, input int ack_at,
                                     input logic [31:0] datr);
    rsp_t r;
    int   w;
    r.dat = '0;
    r.err = 1'b0;
    if (adr < IO_BASE) begin
      if (!wr) r.dat = memfn({adr[31:4], 4'h0});
      return r;
    end
    w = int'(adr[3:2]);
    if (((be >> (12 - 4 * w)) & 16'hF) == 16'h0) return r;
    if (ack_at == 0 || ack_at > WB_TIMEOUT) begin
      r.err = 1'b1;
      return r;
    end
    if (!wr) r.dat = 128'(datr) << (96 - 32 * w);
    return r;
  endfunction

  task automatic chk(input string name, input logic [383:0] act, input logic [383:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Per-cycle compare: ready tracks outstanding work, responses match the model
  // in order, and the response fields hold between responses.
  always @(negedge clk) begin
    if (rst_b) begin
      chk("req_rdy", req_rdy, !busy);
      if (rsp_val) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", rsp_val, 0);
        end else begin
          cmp_e = exp_q.pop_front();
          chk("rsp_dat", rsp_dat, cmp_e.dat);
          chk("rsp_err", rsp_err, cmp_e.err);
          last_dat = cmp_e.dat;
          last_err = cmp_e.err;
        end
        busy = 1'b0;
      end else begin
        chk("rsp_dat_hold", rsp_dat, last_dat);
        chk("rsp_err_hold", rsp_err, last_err);
      end
    end
  end

  // One request from a negedge to the idle cycle after its response.
  // ack_at: cyc cycle (1-based) in which the slave acks; 0 = never.
  task automatic do_req(input logic wr, input logic [31:0] adr, input logic [15:0] be,
                        input logic [127:0] dat, input int ack_at, input logic [31:0] datr,
                        output logic [127:0] got_dat, output logic got_err);
    int   w;
    logic [3:0] nib;
    int   n;
    int   exp_len;
    bit   ok;
    w   = int'(adr[3:2]);
    nib = 4'((be >> (12 - 4 * w)) & 16'hF);
    exp_q.push_back(model_rsp(wr, adr, be, ack_at, datr));
    req_val = 1'b1; req_wr = wr; req_adr = adr; req_be = be; req_dat = dat;
    got_dat = 'x; got_err = 1'bx;
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (req_rdy) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("accept", ok, 1);
    if (!ok) begin req_val = 1'b0; return; end
    @(posedge clk);
    busy = 1'b1;
    @(negedge clk);
    req_val = 1'b0;
    if (adr < IO_BASE) begin
      chk("mem_adr", mem_adr, {adr[31:4], 4'h0});
      chk("mem_wr_val", mem_wr_val, wr);
      if (wr) begin
        chk("mem_wr_be", mem_wr_be, be);
        chk("mem_wr_dat", mem_wr_dat, dat);
      end
      chk("wb_cyc_mem", wb_cyc, 0);
      chk("rsp_early", rsp_val, 0);
      @(negedge clk);
      chk("mem_wr_off", mem_wr_val, 0);
    end else if (nib == 4'h0) begin
      chk("wb_nocyc", wb_cyc, 0);
    end else begin
      chk("wb_adr", wb_adr, {adr[31:2], 2'b00});
      chk("wb_sel", wb_sel, nib);
      chk("wb_we", wb_we, wr);
      chk("wb_datw", wb_datw, 32'(dat >> (96 - 32 * w)));
      exp_len = (ack_at == 0 || ack_at > WB_TIMEOUT) ? WB_TIMEOUT : ack_at;
      n = 0;
      for (int i = 0; i < 400; i++) begin
        if (!wb_cyc) break;
        n++;
        chk("wb_stb", wb_stb, 1);
        if (n == ack_at) begin wb_ack = 1'b1; wb_datr = datr; end
        else wb_ack = 1'b0;
        @(negedge clk);
      end
      wb_ack = 1'b0;
      chk("wb_cyc_len", n, exp_len);
    end
    chk("rsp_val", rsp_val, 1);
    got_dat = rsp_dat;
    got_err = rsp_err;
    @(negedge clk);
    chk("rsp_once", rsp_val, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_pass = 0; n_total = 0; busy = 1'b0; last_dat = '0; last_err = 1'b0;
    rst_b = 1'b0; req_val = 1'b0; req_wr = 1'b0; req_adr = '0; req_be = '0;
    req_dat = '0; wb_ack = 1'b0; wb_datr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", outs_all, 0);
    #2 rst_b = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst", req_rdy, 1);

    // MEM load with known line
    do_req(1'b0, 32'h0000_1234, 16'hFFFF, '0, 0, '0, gd, ge);
    chk("pin_memld", gd, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    // MEM store, partial enables
    do_req(1'b1, 32'h0000_0100, 16'hF00F, 128'h01020304_05060708_090A0B0C_0D0E0F10, 0, '0, gd, ge);
    chk("pin_memst", gd, 128'h0);
    // Last MEM address
    do_req(1'b0, 32'h7FFF_FFFF, 16'hFFFF, '0, 0, '0, gd, ge);
    // WB load, word 2, ack in 3rd cycle
    do_req(1'b0, 32'h8000_0008, 16'h00F0, '0, 3, 32'hDEAD_BEEF, gd, ge);
    chk("pin_wbld", gd, 128'h00000000_00000000_DEADBEEF_00000000);
    chk("pin_wbld_err", ge, 0);
    // WB partial store, word 1, one lane
    do_req(1'b1, 32'h8000_0004, 16'h0800, 128'h11111111_A5A5C3C3_22222222_33333333, 1, 32'hFFFF_FFFF, gd, ge);
    chk("pin_wbst", gd, 128'h0);
    // Zero-nibble store: no bus cycle
    do_req(1'b1, 32'h8000_000C, 16'hFFF0, 128'h1, 0, '0, gd, ge);
    chk("pin_zero_err", ge, 0);
    // Exactly IO_BASE goes to Wishbone, word 0
    do_req(1'b0, 32'h8000_0000, 16'hF000, '0, 2, 32'h1234_5678, gd, ge);
    chk("pin_iobase", gd, 128'h12345678_00000000_00000000_00000000);
    // Timeout
    do_req(1'b0, 32'h8000_0010, 16'hFFFF, '0, 0, '0, gd, ge);
    chk("pin_to_err", ge, 1);
    chk("pin_to_dat", gd, 128'h0);
    // Ack in the last allowed cycle wins
    do_req(1'b0, 32'h8000_001C, 16'h000F, '0, WB_TIMEOUT, 32'hCAFE_F00D, gd, ge);
    chk("pin_lastack", gd, 128'h00000000_00000000_00000000_CAFEF00D);
    chk("pin_lastack_err", ge, 0);
    // Normal request after timeout
    do_req(1'b0, 32'h0000_2000, 16'hFFFF, '0, 0, '0, gd, ge);

    // Reset in the middle of a Wishbone cycle
    req_val = 1'b1; req_wr = 1'b0; req_adr = 32'h8000_0020; req_be = 16'hFFFF; req_dat = '0;
    @(posedge clk);
    busy = 1'b1;
    @(negedge clk);
    req_val = 1'b0;
    repeat (3) @(negedge clk);
    chk("cyc_before_rst", wb_cyc, 1);
    #2 rst_b = 1'b0;
    #1;
    chk("midrst_outs", outs_all, 0);
    exp_q.delete();
    busy = 1'b0; last_dat = '0; last_err = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rdy_after_midrst", req_rdy, 1);
    do_req(1'b0, 32'h0000_1230, 16'hFFFF, '0, 0, '0, gd, ge);
    chk("pin_post_rst", gd, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
